// File: rtl/interp_lin.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | interp_lin : linear-interpolating upsampler by 2**LOG2_R, one adder.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module interp_lin #(
  parameter int IO_B   = 16,
  parameter int LOG2_R = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IO_B-1:0] in_data,
  input  logic            in_valid,
  output logic [IO_B-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overrun,
  input  logic            clr_overrun
);

  localparam int AW = IO_B + LOG2_R + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IO_B-1:0]     x_prev, x_cur, hold_data;
  logic                hold_vld;
  logic signed [IO_B:0] diff;
  logic signed [AW-1:0] acc;
  logic [LOG2_R-1:0]   k;

  logic xfer, last;
  logic set_prev, start, from_hold, to_hold, drop;
  logic [IO_B-1:0]      seg_sample, seg_base;
  logic signed [IO_B:0] diff_nxt;
  logic [AW-1:0]        acc_load;

  assign xfer = (state == EMIT) && out_ready;
  assign last = xfer && (&k);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_prev  = 1'b0;
    start     = 1'b0;
    from_hold = 1'b0;
    to_hold   = 1'b0;
    drop      = 1'b0;
    unique case (state)
      EMPTY: if (in_valid) begin
        set_prev  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (in_valid) begin
        start     = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
        if (last) begin
          // A held sample has priority; a fresh input then refills the freed slot.
          if (hold_vld) begin
            start     = 1'b1;
            from_hold = 1'b1;
            to_hold   = in_valid;
          end else if (in_valid) begin
            start     = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end else if (in_valid) begin
          if (hold_vld) drop    = 1'b1;
          else          to_hold = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // A segment started from EMIT continues from the just-finished endpoint.
  assign seg_sample = from_hold ? hold_data : in_data;
  assign seg_base   = (state == EMIT) ? x_cur : x_prev;
  assign diff_nxt   = $signed({1'b0, seg_sample}) - $signed({1'b0, seg_base});
  assign acc_load   = {1'b0, seg_base, {LOG2_R{1'b0}}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_prev    <= '0;
      x_cur     <= '0;
      hold_data <= '0;
      hold_vld  <= 1'b0;
      diff      <= '0;
      acc       <= '0;
      k         <= '0;
      overrun   <= 1'b0;
    end else begin
      if (set_prev) x_prev <= in_data;
      if (last)     x_prev <= x_cur;

      if (start) begin
        x_cur <= seg_sample;
        diff  <= diff_nxt;
        acc   <= acc_load;
        k     <= '0;
      end else if (xfer) begin
        acc <= acc + {{LOG2_R{diff[IO_B]}}, diff};
        k   <= k + 1'b1;
      end

      if (to_hold) begin
        hold_data <= in_data;
        hold_vld  <= 1'b1;
      end else if (from_hold) begin
        hold_vld  <= 1'b0;
      end

      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // acc stays non-negative, so the slice equals the floor of acc/R.
  assign out_data  = acc[IO_B+LOG2_R-1:LOG2_R];
  assign out_valid = (state == EMIT);

endmodule
`default_nettype wire

// File: tb/tb_interp_lin.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_interp_lin : directed + random bench for interp_lin with queue model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_interp_lin;
  localparam int IO_B   = 16;
  localparam int LOG2_R = 2;
  localparam int R      = 1 << LOG2_R;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [IO_B-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            clr_overrun = 1'b0;
  logic [IO_B-1:0] out_data;
  logic            out_valid;
  logic            overrun;

  interp_lin #(.IO_B(IO_B), .LOG2_R(LOG2_R)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  // Reference: pending outputs, one waiting sample, last endpoint, sticky flag.
  int exp_q[$];
  int pend[$];
  int seen[$];
  int prev;
  bit have_prev;
  bit ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    pend.delete();
    have_prev = 1'b0;
    prev      = 0;
    ov        = 1'b0;
  endfunction

  function automatic void start_seg(input int b);
    for (int j = 0; j < R; j++)
      exp_q.push_back((prev * R + j * (b - prev)) / R);
    prev = b;
  endfunction

  task automatic cycle(input bit v, input int d, input bit rdy, input bit clr);
    bit dropped;
    logic [31:0] dv;
    dv          = d;
    in_valid    = v;
    in_data     = dv[IO_B-1:0];
    out_ready   = rdy;
    clr_overrun = clr;
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
    if (exp_q.size() > 0) chk("out_data", {16'b0, out_data}, exp_q[0]);
    chk("overrun", {31'b0, overrun}, {31'b0, ov});
    if (out_valid && rdy) seen.push_back(int'(out_data));
    dropped = 1'b0;
    if (exp_q.size() > 0 && rdy) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0 && pend.size() > 0) start_seg(pend.pop_front());
    end
    if (v) begin
      if (!have_prev) begin
        prev      = d;
        have_prev = 1'b1;
      end else if (exp_q.size() == 0) start_seg(d);
      else if (pend.size() == 0)      pend.push_back(d);
      else                            dropped = 1'b1;
    end
    if (dropped)  ov = 1'b1;
    else if (clr) ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic check_seen(input string tag, input int a, input int b, input int c, input int d);
    int ref_v[4];
    ref_v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      if (seen.size() > 0) chk(tag, seen.pop_front(), ref_v[i]);
      else                 chk(tag, 32'hFFFF_FFFF, ref_v[i]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'b0, out_data},  32'd0);
    chk("rst_overrun",   {31'b0, overrun},   32'd0);
    model_reset();
    seen.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Rising ramp, then falling ramp with floor rounding.
    cycle(1'b1, 1000, 1'b1, 1'b0);
    cycle(1'b1, 2000, 1'b1, 1'b0);
    idle(5);
    check_seen("t1", 1000, 1250, 1500, 1750);
    cycle(1'b1, 1000, 1'b1, 1'b0);
    idle(5);
    check_seen("t2", 2000, 1750, 1500, 1250);

    // Full-scale swing.
    do_reset();
    cycle(1'b1, 0, 1'b1, 1'b0);
    cycle(1'b1, 65535, 1'b1, 1'b0);
    idle(5);
    check_seen("t3a", 0, 16383, 32767, 49151);
    cycle(1'b1, 0, 1'b1, 1'b0);
    idle(5);
    check_seen("t3b", 65535, 49151, 32767, 16383);

    // Backpressure: outputs held while stalled.
    cycle(1'b1, 400, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    idle(4);
    check_seen("t4", 0, 100, 200, 300);

    // Hold buffer fill, overrun, back-to-back segments, clear.
    cycle(1'b1, 800, 1'b1, 1'b0);
    cycle(1'b1, 1200, 1'b0, 1'b0);
    cycle(1'b1, 1600, 1'b0, 1'b0);
    cycle(1'b1, 2000, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    idle(10);
    check_seen("t5a", 400, 500, 600, 700);
    check_seen("t5b", 800, 900, 1000, 1100);
    cycle(1'b0, 0, 1'b1, 1'b1);
    idle(2);

    // Final transfer with hold full and a new input: no drop.
    cycle(1'b1, 1300, 1'b1, 1'b0);
    cycle(1'b1, 1400, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 1500, 1'b1, 1'b0);
    idle(10);
    seen.delete();

    // Reset mid-segment at k=2, then restart from EMPTY.
    cycle(1'b1, 1600, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    #2;
    do_reset();
    cycle(1'b1, 10, 1'b1, 1'b0);
    cycle(1'b1, 50, 1'b1, 1'b0);
    idle(5);
    check_seen("t6", 10, 20, 30, 40);

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 65535)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    end
    idle(20);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
`default_nettype wire
